falafel_input_parser_mp: RTL and testbench
==========================================

Name: falafel_input_parser_mp

Overview:
Multi-port successor to the single-stream falafel input parser. Accepts two-beat request packets from N_PORTS independent valid/ready request ports and arbitrates between them round-robin. Each decoded request is routed to the alloc FIFO, the free FIFO or the config-register write port, and tagged with its source port. Sits between the host/request fabric and the falafel allocator FIFOs.

Parameters:
- N_PORTS, 4, number of request ports (1..16).
- DATA_W, 64, request beat width; also the id, size and config field width.
- ERR_CNT_W, 8, width of the saturating illegal-opcode counter.
- PORT_W, $clog2(N_PORTS) (minimum 1), derived localparam, width of the port tag.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_val_i  in  N_PORTS  per-port beat valid.
- req_rdy_o  out  N_PORTS  per-port beat ready.
- req_data_i  in  N_PORTS*DATA_W  per-port beat data; port p occupies bits [p*DATA_W +: DATA_W].
- alloc_req_val_o  out  1  alloc entry valid.
- alloc_req_rdy_i  in  1  alloc FIFO ready.
- alloc_req_data_o  out  alloc_entry_t  {id, size} alloc entry.
- alloc_req_port_o  out  PORT_W  source port of the alloc entry.
- free_req_val_o  out  1  free entry valid.
- free_req_rdy_i  in  1  free FIFO ready.
- free_req_data_o  out  alloc_entry_t  {id, size} free entry.
- free_req_port_o  out  PORT_W  source port of the free entry.
- config_reg_write_o  out  1  one-cycle config write strobe.
- config_reg_addr_o  out  DATA_W  config address.
- config_reg_data_o  out  DATA_W  config data.
- err_cnt_o  out  ERR_CNT_W  count of illegal-opcode packets, saturating.

Behaviour:
- Clock is clk_i. Reset rst_ni is asynchronous, active-low.
- Packet format:
  - Beat 0 (header): opcode = [DATA_W-1:DATA_W-2]; payload = [DATA_W-3:0], zero-extended to DATA_W.
  - Beat 1 (body): size for alloc/free, data for config.
  - Opcodes: 00 alloc (payload = id), 01 free (payload = id), 10 config write (payload = addr), 11 illegal.
- Reset values: FSM in ARB, round-robin pointer 0. All req_rdy_o, alloc_req_val_o, free_req_val_o and config_reg_write_o are 0. All data, addr, port and err_cnt_o outputs are 0.
- FSM states:
  - ARB:
    - Grant = first port with req_val_i=1, searching upward from the pointer and wrapping at N_PORTS.
    - req_rdy_o is 1 only on the granted port. Readiness is combinational from req_val_i; no other port is ever ready.
    - On the header handshake: latch opcode, payload and grant, then go to BODY.
    - No valid port: stay in ARB.
  - BODY:
    - Lock to the latched port; req_rdy_o is 1 on that port only.
    - Other ports stall even if valid; the locked port may stall indefinitely.
    - On the body handshake: latch the beat.
      - Opcode 00 or 01: go to OUT.
      - Opcode 10: go to CFG.
      - Opcode 11: increment err_cnt_o, saturating at all-ones, then go to ARB (packet dropped).
  - OUT:
    - Assert alloc_req_val_o (opcode 00) or free_req_val_o (opcode 01), with registered data and port.
    - Hold val and data stable until the matching rdy is seen high at a clock edge, then go to ARB.
    - All req_rdy_o are 0 in OUT.
  - CFG:
    - config_reg_write_o=1 for exactly one cycle with addr/data, then go to ARB.
- Pointer update: on every packet completion (OUT handshake, CFG, or illegal drop), pointer = latched grant + 1, wrapping at N_PORTS to 0. This gives fairness: a continuously valid port cannot win twice while another port waits.
- Latency: header at cycle t, body at t+1 gives out-val at t+2 or config strobe at t+2. Best throughput is one packet per 3 cycles.
- Alloc and free valids are never asserted together. At most one packet is in flight.
- Reset mid-packet: partial packet discarded and the FSM returns to ARB. Upstream must resend from the header.
- N_PORTS=1: the arbiter degenerates; behaviour is otherwise identical.

Test Plan:
- Port 0 sends header {00, id=0x5}, then body 0x40; alloc rdy=1 -> alloc_req_val_o high at cycle t+2 with id=5, size=0x40, port=0, for one cycle.
- Port 2 sends free {01, id=0x9}, body 0x80; free rdy held 0 for 5 cycles -> val and data stable for 6 cycles; req_rdy_o all 0 throughout; drops after the rdy=1 edge.
- Ports 0,1,3 continuously valid with alloc packets -> grant order 0,1,3,0,1,3; port 2 never ready.
- Config packet {10, addr=0x10}, body 0xDEAD -> exactly one config_reg_write_o pulse with addr 0x10, data 0xDEAD; no alloc/free valid.
- 300 illegal-opcode (11) packets with ERR_CNT_W=8 -> err_cnt_o saturates at 255; no output activity.
- rst_ni asserted during BODY -> outputs immediately return to reset values; the next header is accepted from port 0 under pointer 0.

Source files
------------

// File: rtl/falafel_input_parser_mp.sv
`default_nettype none
// ============================================================================
// Module      : falafel_input_parser_mp
// Description : Multi-port request parser. Round-robin arbitrates two-beat
//               request packets from N_PORTS valid/ready ports, decodes the
//               opcode and routes each packet to the alloc FIFO, the free
//               FIFO or the config-register write port, tagged with its
//               source port. Illegal opcodes are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module falafel_input_parser_mp #(
    parameter  int N_PORTS   = 4,
    parameter  int DATA_W    = 64,
    parameter  int ERR_CNT_W = 8,
    localparam int PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    // Request ports
    input  logic [N_PORTS-1:0]        req_val_i,
    output logic [N_PORTS-1:0]        req_rdy_o,
    input  logic [N_PORTS*DATA_W-1:0] req_data_i,
    // Alloc FIFO write side; data is {id, size}
    output logic                     alloc_req_val_o,
    input  logic                     alloc_req_rdy_i,
    output logic [2*DATA_W-1:0]      alloc_req_data_o,
    output logic [PORT_W-1:0]        alloc_req_port_o,
    // Free FIFO write side; data is {id, size}
    output logic                     free_req_val_o,
    input  logic                     free_req_rdy_i,
    output logic [2*DATA_W-1:0]      free_req_data_o,
    output logic [PORT_W-1:0]        free_req_port_o,
    // Config register write port
    output logic                     config_reg_write_o,
    output logic [DATA_W-1:0]        config_reg_addr_o,
    output logic [DATA_W-1:0]        config_reg_data_o,
    // Saturating illegal-opcode counter
    output logic [ERR_CNT_W-1:0]     err_cnt_o
);

    // Header opcode encodings (top two bits of beat 0)
    localparam logic [1:0] c_OP_ALLOC = 2'b00;
    localparam logic [1:0] c_OP_FREE  = 2'b01;
    localparam logic [1:0] c_OP_CFG   = 2'b10;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_BODY = 2'd1,
        ST_OUT  = 2'd2,
        ST_CFG  = 2'd3
    } state_t;

    state_t                r_state;
    logic [PORT_W-1:0]     r_ptr;
    logic [PORT_W-1:0]     r_grant;
    logic [1:0]            r_opcode;
    logic [DATA_W-1:0]     r_payload;

    logic                  r_alloc_val;
    logic [2*DATA_W-1:0]   r_alloc_data;
    logic [PORT_W-1:0]     r_alloc_port;
    logic                  r_free_val;
    logic [2*DATA_W-1:0]   r_free_data;
    logic [PORT_W-1:0]     r_free_port;
    logic                  r_cfg_wr;
    logic [DATA_W-1:0]     r_cfg_addr;
    logic [DATA_W-1:0]     r_cfg_data;
    logic [ERR_CNT_W-1:0]  r_err;

    logic                  w_any;
    logic [PORT_W-1:0]     w_grant;
    int                    w_idx;
    logic [N_PORTS-1:0]    w_rdy;
    logic [DATA_W-1:0]     w_hdr_beat;
    logic [DATA_W-1:0]     w_body_beat;
    logic                  w_body_hs;
    logic                  w_out_done;
    logic [PORT_W-1:0]     w_ptr_next;

    // Round-robin search: first valid port at or above the pointer, wrapping
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_idx = (int'(r_ptr) + i) % N_PORTS;
            if (!w_any && req_val_i[w_idx]) begin
                w_any   = 1'b1;
                w_grant = PORT_W'(w_idx);
            end
        end
    end

    // Ready is one-hot: the arbitration winner in ARB, the locked port in BODY
    always_comb begin
        w_rdy = '0;
        case (r_state)
            ST_ARB:  if (w_any) w_rdy[w_grant] = 1'b1;
            ST_BODY: w_rdy[r_grant] = 1'b1;
            default: w_rdy = '0;
        endcase
    end

    // No beat is accepted while reset is held, even though ready is combinational
    assign req_rdy_o = w_rdy & {N_PORTS{rst_ni}};

    assign w_hdr_beat  = req_data_i[int'(w_grant)*DATA_W +: DATA_W];
    assign w_body_beat = req_data_i[int'(r_grant)*DATA_W +: DATA_W];
    assign w_body_hs   = req_val_i[r_grant];
    assign w_out_done  = (r_alloc_val && alloc_req_rdy_i) ||
                         (r_free_val  && free_req_rdy_i);

    // Next pointer is one past the port that just completed a packet
    assign w_ptr_next  = (r_grant == PORT_W'(N_PORTS - 1)) ? '0
                                                           : r_grant + PORT_W'(1);

    // Packet FSM: header latch, body decode, output hold and pointer update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_ARB;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_opcode     <= '0;
            r_payload    <= '0;
            r_alloc_val  <= 1'b0;
            r_alloc_data <= '0;
            r_alloc_port <= '0;
            r_free_val   <= 1'b0;
            r_free_data  <= '0;
            r_free_port  <= '0;
            r_cfg_wr     <= 1'b0;
            r_cfg_addr   <= '0;
            r_cfg_data   <= '0;
            r_err        <= '0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_any) begin
                        r_grant   <= w_grant;
                        r_opcode  <= w_hdr_beat[DATA_W-1 -: 2];
                        r_payload <= {2'b00, w_hdr_beat[DATA_W-3:0]};
                        r_state   <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (w_body_hs) begin
                        case (r_opcode)
                            c_OP_ALLOC: begin
                                r_alloc_val  <= 1'b1;
                                r_alloc_data <= {r_payload, w_body_beat};
                                r_alloc_port <= r_grant;
                                r_state      <= ST_OUT;
                            end
                            c_OP_FREE: begin
                                r_free_val   <= 1'b1;
                                r_free_data  <= {r_payload, w_body_beat};
                                r_free_port  <= r_grant;
                                r_state      <= ST_OUT;
                            end
                            c_OP_CFG: begin
                                r_cfg_wr     <= 1'b1;
                                r_cfg_addr   <= r_payload;
                                r_cfg_data   <= w_body_beat;
                                r_state      <= ST_CFG;
                            end
                            default: begin
                                // Illegal opcode: drop the packet, count it
                                if (r_err != {ERR_CNT_W{1'b1}}) begin
                                    r_err <= r_err + ERR_CNT_W'(1);
                                end
                                r_ptr   <= w_ptr_next;
                                r_state <= ST_ARB;
                            end
                        endcase
                    end
                end
                ST_OUT: begin
                    if (w_out_done) begin
                        r_alloc_val <= 1'b0;
                        r_free_val  <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= ST_ARB;
                    end
                end
                ST_CFG: begin
                    r_cfg_wr <= 1'b0;
                    r_ptr    <= w_ptr_next;
                    r_state  <= ST_ARB;
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

    assign alloc_req_val_o    = r_alloc_val;
    assign alloc_req_data_o   = r_alloc_data;
    assign alloc_req_port_o   = r_alloc_port;
    assign free_req_val_o     = r_free_val;
    assign free_req_data_o    = r_free_data;
    assign free_req_port_o    = r_free_port;
    assign config_reg_write_o = r_cfg_wr;
    assign config_reg_addr_o  = r_cfg_addr;
    assign config_reg_data_o  = r_cfg_data;
    assign err_cnt_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_falafel_input_parser_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_falafel_input_parser_mp
// Description : Self-checking bench for falafel_input_parser_mp: directed
//               latency/backpressure/config/reset scenarios plus randomized
//               multi-port traffic against a packet-level round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_falafel_input_parser_mp;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int EW = 8;
    localparam int PW = 2;

    logic              clk_i;
    logic              rst_ni;
    logic [N-1:0]      req_val_i;
    logic [N-1:0]      req_rdy_o;
    logic [N*DW-1:0]   req_data_i;
    logic              alloc_req_val_o;
    logic              alloc_req_rdy_i;
    logic [2*DW-1:0]   alloc_req_data_o;
    logic [PW-1:0]     alloc_req_port_o;
    logic              free_req_val_o;
    logic              free_req_rdy_i;
    logic [2*DW-1:0]   free_req_data_o;
    logic [PW-1:0]     free_req_port_o;
    logic              config_reg_write_o;
    logic [DW-1:0]     config_reg_addr_o;
    logic [DW-1:0]     config_reg_data_o;
    logic [EW-1:0]     err_cnt_o;

    falafel_input_parser_mp #(.N_PORTS(N), .DATA_W(DW), .ERR_CNT_W(EW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .req_val_i          (req_val_i),
        .req_rdy_o          (req_rdy_o),
        .req_data_i         (req_data_i),
        .alloc_req_val_o    (alloc_req_val_o),
        .alloc_req_rdy_i    (alloc_req_rdy_i),
        .alloc_req_data_o   (alloc_req_data_o),
        .alloc_req_port_o   (alloc_req_port_o),
        .free_req_val_o     (free_req_val_o),
        .free_req_rdy_i     (free_req_rdy_i),
        .free_req_data_o    (free_req_data_o),
        .free_req_port_o    (free_req_port_o),
        .config_reg_write_o (config_reg_write_o),
        .config_reg_addr_o  (config_reg_addr_o),
        .config_reg_data_o  (config_reg_data_o),
        .err_cnt_o          (err_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]    op;
        logic [DW-1:0] pl;
        logic [DW-1:0] body;
    } pkt_t;

    // kind: 0 alloc, 1 free, 2 config (port field 0 for config)
    typedef struct packed {
        logic [1:0]    kind;
        logic [3:0]    port;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } ev_t;

    int      n_checks = 0;
    int      n_fail   = 0;

    pkt_t    pkt_q [N][$];
    ev_t     obs_q[$];
    ev_t     exp_q[$];
    int      grant_q[$];
    int      exp_grant_q[$];
    int      exp_err;
    logic [N-1:0] rdy_seen;
    int      both_val_cnt;
    int      multi_rdy_cnt;
    bit      rand_rdy;
    bit      traffic_timeout;

    function automatic logic [DW-1:0] hdr(input logic [1:0] op, input logic [DW-1:0] pl);
        return {op, pl[DW-3:0]};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic [DW-1:0] d);
        req_val_i[p] = v;
        req_data_i[p*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_val_i = '0;
        req_data_i = '0;
        alloc_req_rdy_i = 1'b0;
        free_req_rdy_i = 1'b0;
        for (int p = 0; p < N; p++) pkt_q[p].delete();
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Drives all queued packets concurrently; each port stays valid while it
    // has beats left. Records output events and header grant order.
    task automatic run_traffic(input int max_cyc);
        int pidx[N];
        bit ph[N];
        logic [N-1:0] hs;
        int idle;
        bit pending;
        bit busy;
        obs_q.delete();
        grant_q.delete();
        rdy_seen = '0;
        both_val_cnt = 0;
        multi_rdy_cnt = 0;
        idle = 0;
        for (int p = 0; p < N; p++) begin
            pidx[p] = 0;
            ph[p] = 1'b0;
        end
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            pending = 1'b0;
            for (int p = 0; p < N; p++) begin
                if (pidx[p] < pkt_q[p].size()) begin
                    pending = 1'b1;
                    set_port(p, 1'b1, ph[p] ? pkt_q[p][pidx[p]].body
                                            : hdr(pkt_q[p][pidx[p]].op, pkt_q[p][pidx[p]].pl));
                end else begin
                    set_port(p, 1'b0, '0);
                end
            end
            alloc_req_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            free_req_rdy_i  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk_i);
            hs = req_val_i & req_rdy_o;
            rdy_seen = rdy_seen | req_rdy_o;
            if ($countones(req_rdy_o) > 1) multi_rdy_cnt++;
            if (alloc_req_val_o && free_req_val_o) both_val_cnt++;
            if (alloc_req_val_o && alloc_req_rdy_i)
                obs_q.push_back('{2'd0, 4'(alloc_req_port_o), alloc_req_data_o[2*DW-1:DW], alloc_req_data_o[DW-1:0]});
            if (free_req_val_o && free_req_rdy_i)
                obs_q.push_back('{2'd1, 4'(free_req_port_o), free_req_data_o[2*DW-1:DW], free_req_data_o[DW-1:0]});
            if (config_reg_write_o)
                obs_q.push_back('{2'd2, 4'd0, config_reg_addr_o, config_reg_data_o});
            busy = alloc_req_val_o || free_req_val_o || config_reg_write_o;
            tick();
            for (int p = 0; p < N; p++) begin
                if (hs[p]) begin
                    if (!ph[p]) grant_q.push_back(p);
                    else pidx[p]++;
                    ph[p] = !ph[p];
                end
            end
            if (!pending && !busy) idle++;
            else idle = 0;
            if (idle >= 3) break;
        end
        traffic_timeout = (idle < 3);
        req_val_i = '0;
        req_data_i = '0;
    endtask

    // Packet-level reference: repeatedly serve the first port with packets
    // left, searching upward from the pointer; pointer moves past the winner.
    task automatic model_expect(input int start_err);
        int nxt[N];
        int ptr;
        int found;
        pkt_t pk;
        exp_q.delete();
        exp_grant_q.delete();
        exp_err = start_err;
        ptr = 0;
        for (int p = 0; p < N; p++) nxt[p] = 0;
        forever begin
            found = -1;
            for (int i = 0; i < N; i++) begin
                if (found < 0 && nxt[(ptr + i) % N] < pkt_q[(ptr + i) % N].size())
                    found = (ptr + i) % N;
            end
            if (found < 0) break;
            pk = pkt_q[found][nxt[found]];
            nxt[found]++;
            exp_grant_q.push_back(found);
            case (pk.op)
                2'b00: exp_q.push_back('{2'd0, 4'(found), pk.pl, pk.body});
                2'b01: exp_q.push_back('{2'd1, 4'(found), pk.pl, pk.body});
                2'b10: exp_q.push_back('{2'd2, 4'd0, pk.pl, pk.body});
                default: exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            endcase
            ptr = (found + 1) % N;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_val_i = '1;
        req_data_i = '0;
        #1;
        n_checks++;
        if (req_rdy_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rdy_in_reset: got %b want 0000", req_rdy_o);
        end
        do_reset();
        @(negedge clk_i);
        n_checks++;
        if ({alloc_req_val_o, free_req_val_o, config_reg_write_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_valids: got %b want 000", {alloc_req_val_o, free_req_val_o, config_reg_write_o});
        end
        n_checks++;
        if ({alloc_req_data_o, free_req_data_o, config_reg_addr_o, config_reg_data_o,
             alloc_req_port_o, free_req_port_o, err_cnt_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: alloc %h free %h addr %h data %h err %0d want all 0",
                     alloc_req_data_o, free_req_data_o, config_reg_addr_o, config_reg_data_o, err_cnt_o);
        end
        n_checks++;
        if (req_rdy_o !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_rdy_idle: got %b want 0000", req_rdy_o);
        end
    endtask

    task automatic test_alloc_basic();
        do_reset();
        alloc_req_rdy_i = 1'b1;
        set_port(0, 1'b1, hdr(2'b00, 64'h5));
        @(negedge clk_i);
        n_checks++;
        if (req_rdy_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL alloc_hdr_rdy: got %b want 0001", req_rdy_o);
        end
        tick();
        set_port(0, 1'b1, 64'h40);
        @(negedge clk_i);
        n_checks++;
        if (req_rdy_o !== 4'b0001 || alloc_req_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_body_cycle: rdy %b val %b want 0001 0", req_rdy_o, alloc_req_val_o);
        end
        tick();
        set_port(0, 1'b0, '0);
        @(negedge clk_i);
        n_checks++;
        if (alloc_req_val_o !== 1'b1 || alloc_req_data_o !== {64'h5, 64'h40} || alloc_req_port_o !== 2'd0) begin
            n_fail++;
            $display("FAIL alloc_out: val %b data %h port %0d want 1 %h 0",
                     alloc_req_val_o, alloc_req_data_o, alloc_req_port_o, {64'h5, 64'h40});
        end
        n_checks++;
        if (req_rdy_o !== 4'b0000 || free_req_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_out_side: rdy %b free_val %b want 0000 0", req_rdy_o, free_req_val_o);
        end
        tick();
        @(negedge clk_i);
        n_checks++;
        if (alloc_req_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_one_cycle: val %b want 0", alloc_req_val_o);
        end
    endtask

    task automatic test_free_stall();
        do_reset();
        free_req_rdy_i = 1'b0;
        set_port(2, 1'b1, hdr(2'b01, 64'h9));
        tick();
        set_port(2, 1'b1, 64'h80);
        tick();
        set_port(2, 1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) free_req_rdy_i = 1'b1;
            @(negedge clk_i);
            n_checks++;
            if (free_req_val_o !== 1'b1 || free_req_data_o !== {64'h9, 64'h80} || free_req_port_o !== 2'd2
                || req_rdy_o !== 4'b0000 || alloc_req_val_o !== 1'b0) begin
                n_fail++;
                $display("FAIL free_stall cyc %0d: val %b data %h port %0d rdy %b aval %b want 1 %h 2 0000 0",
                         k, free_req_val_o, free_req_data_o, free_req_port_o, req_rdy_o, alloc_req_val_o,
                         {64'h9, 64'h80});
            end
            tick();
        end
        @(negedge clk_i);
        n_checks++;
        if (free_req_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL free_drop: val %b want 0", free_req_val_o);
        end
        free_req_rdy_i = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_order[6];
        exp_order = '{0, 1, 3, 0, 1, 3};
        do_reset();
        rand_rdy = 1'b0;
        for (int r = 0; r < 2; r++) begin
            pkt_q[0].push_back('{2'b00, 64'(16 + r), 64'(100 + r)});
            pkt_q[1].push_back('{2'b00, 64'(32 + r), 64'(200 + r)});
            pkt_q[3].push_back('{2'b00, 64'(48 + r), 64'(300 + r)});
        end
        run_traffic(200);
        n_checks++;
        if (traffic_timeout || grant_q.size() != 6 || obs_q.size() != 6) begin
            n_fail++;
            $display("FAIL rr_counts: timeout %0d grants %0d events %0d want 0 6 6",
                     traffic_timeout, grant_q.size(), obs_q.size());
        end
        for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
            n_checks++;
            if (grant_q[i] != exp_order[i]) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %0d want %0d", i, grant_q[i], exp_order[i]);
            end
        end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].port != 4'(exp_order[i]) || obs_q[i].kind != 2'd0) begin
                n_fail++;
                $display("FAIL rr_event[%0d]: kind %0d port %0d want 0 %0d", i, obs_q[i].kind, obs_q[i].port, exp_order[i]);
            end
        end
        n_checks++;
        if (rdy_seen[2] !== 1'b0 || multi_rdy_cnt != 0) begin
            n_fail++;
            $display("FAIL rr_port2_rdy: seen %b multi %0d want 0 0", rdy_seen[2], multi_rdy_cnt);
        end
    endtask

    task automatic test_config();
        int pulses;
        int other_val;
        do_reset();
        alloc_req_rdy_i = 1'b1;
        free_req_rdy_i = 1'b1;
        set_port(1, 1'b1, hdr(2'b10, 64'h10));
        tick();
        set_port(1, 1'b1, 64'hDEAD);
        tick();
        set_port(1, 1'b0, '0);
        pulses = 0;
        other_val = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (k == 0) begin
                n_checks++;
                if (config_reg_write_o !== 1'b1 || config_reg_addr_o !== 64'h10 || config_reg_data_o !== 64'hDEAD) begin
                    n_fail++;
                    $display("FAIL cfg_pulse: wr %b addr %h data %h want 1 10 dead",
                             config_reg_write_o, config_reg_addr_o, config_reg_data_o);
                end
            end
            if (config_reg_write_o) pulses++;
            if (alloc_req_val_o || free_req_val_o) other_val++;
            tick();
        end
        n_checks++;
        if (pulses != 1 || other_val != 0) begin
            n_fail++;
            $display("FAIL cfg_single: pulses %0d other_val %0d want 1 0", pulses, other_val);
        end
    endtask

    task automatic test_illegal_saturate();
        do_reset();
        rand_rdy = 1'b0;
        for (int i = 0; i < 10; i++)
            pkt_q[$urandom_range(0, N-1)].push_back('{2'b11, 64'($urandom), 64'($urandom)});
        run_traffic(1000);
        n_checks++;
        if (traffic_timeout || err_cnt_o !== 8'd10 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_10: timeout %0d err %0d events %0d want 0 10 0",
                     traffic_timeout, err_cnt_o, obs_q.size());
        end
        for (int p = 0; p < N; p++) pkt_q[p].delete();
        for (int i = 0; i < 290; i++)
            pkt_q[$urandom_range(0, N-1)].push_back('{2'b11, 64'($urandom), 64'($urandom)});
        run_traffic(5000);
        n_checks++;
        if (traffic_timeout || err_cnt_o !== 8'd255 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_sat: timeout %0d err %0d events %0d want 0 255 0",
                     traffic_timeout, err_cnt_o, obs_q.size());
        end
    endtask

    task automatic test_reset_mid_body();
        do_reset();
        alloc_req_rdy_i = 1'b1;
        // One completed packet from port 0 moves the pointer to 1
        set_port(0, 1'b1, hdr(2'b00, 64'h1));
        tick();
        set_port(0, 1'b1, 64'h2);
        tick();
        set_port(0, 1'b0, '0);
        tick();
        set_port(2, 1'b1, hdr(2'b00, 64'h22));
        @(negedge clk_i);
        n_checks++;
        if (req_rdy_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_grant2: rdy %b want 0100", req_rdy_o);
        end
        tick();
        set_port(2, 1'b0, '0);
        @(negedge clk_i);
        n_checks++;
        if (req_rdy_o !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_body_lock: rdy %b want 0100", req_rdy_o);
        end
        set_port(0, 1'b1, hdr(2'b00, 64'h33));
        set_port(2, 1'b1, hdr(2'b00, 64'h44));
        #1;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (req_rdy_o !== 4'b0000 || alloc_req_val_o !== 1'b0 || alloc_req_data_o !== '0 || err_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: rdy %b val %b data %h err %0d want 0000 0 0 0",
                     req_rdy_o, alloc_req_val_o, alloc_req_data_o, err_cnt_o);
        end
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (req_rdy_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_ptr0: rdy %b want 0001", req_rdy_o);
        end
        tick();
        set_port(0, 1'b1, 64'h55);
        tick();
        set_port(0, 1'b0, '0);
        set_port(2, 1'b0, '0);
        @(negedge clk_i);
        n_checks++;
        if (alloc_req_val_o !== 1'b1 || alloc_req_data_o !== {64'h33, 64'h55} || alloc_req_port_o !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_after: val %b data %h port %0d want 1 %h 0",
                     alloc_req_val_o, alloc_req_data_o, alloc_req_port_o, {64'h33, 64'h55});
        end
        tick();
    endtask

    task automatic test_random_traffic();
        int n;
        int r;
        pkt_t pk;
        for (int round = 0; round < 4; round++) begin
            do_reset();
            rand_rdy = 1'b1;
            for (int p = 0; p < N; p++) begin
                n = $urandom_range(0, 6);
                for (int i = 0; i < n; i++) begin
                    r = $urandom_range(0, 9);
                    pk.op   = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                    pk.pl   = {2'b00, 30'($urandom), 32'($urandom)};
                    pk.body = {32'($urandom), 32'($urandom)};
                    pkt_q[p].push_back(pk);
                end
            end
            model_expect(0);
            run_traffic(2000);
            n_checks++;
            if (traffic_timeout || obs_q.size() != exp_q.size() || grant_q.size() != exp_grant_q.size()) begin
                n_fail++;
                $display("FAIL rand_counts r%0d: timeout %0d events %0d/%0d grants %0d/%0d",
                         round, traffic_timeout, obs_q.size(), exp_q.size(), grant_q.size(), exp_grant_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_event r%0d[%0d]: got k%0d p%0d %h %h want k%0d p%0d %h %h", round, i,
                             obs_q[i].kind, obs_q[i].port, obs_q[i].a, obs_q[i].b,
                             exp_q[i].kind, exp_q[i].port, exp_q[i].a, exp_q[i].b);
                end
            end
            for (int i = 0; i < grant_q.size() && i < exp_grant_q.size(); i++) begin
                n_checks++;
                if (grant_q[i] != exp_grant_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_grant r%0d[%0d]: got %0d want %0d", round, i, grant_q[i], exp_grant_q[i]);
                end
            end
            n_checks++;
            if (err_cnt_o !== EW'(exp_err) || both_val_cnt != 0 || multi_rdy_cnt != 0) begin
                n_fail++;
                $display("FAIL rand_misc r%0d: err %0d want %0d, both_val %0d multi_rdy %0d want 0 0",
                         round, err_cnt_o, exp_err, both_val_cnt, multi_rdy_cnt);
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        req_val_i = '0;
        req_data_i = '0;
        alloc_req_rdy_i = 1'b0;
        free_req_rdy_i = 1'b0;
        rand_rdy = 1'b0;
        test_reset();
        test_alloc_basic();
        test_free_stall();
        test_round_robin();
        test_config();
        test_illegal_saturate();
        test_reset_mid_body();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
